// File: rtl/axis_pkg.sv
// Shared types and helpers for the weighted round-robin AXI-Stream arbiter.
package axis_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    HOLD   = 2'd2
  } wrr_state_t;

  // Port-index width; a single port still needs one bit of index.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int PORT_NB_DEF = 4;
  localparam int IDX_W_DEF   = idx_w(PORT_NB_DEF);

endpackage

// File: rtl/axis_wrr_arbiter_rr_select.sv
// Rotating-priority search: first requester strictly after ptr, wrapping around.
module rr_select
  import axis_pkg::*;
#(
  parameter int PORT_NB = 4,
  parameter int IDX_W   = idx_w(PORT_NB)
) (
  input  logic [PORT_NB-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [PORT_NB-1:0] grant,
  output logic [IDX_W-1:0]   index,
  output logic               any
);

  always_comb begin
    grant = '0;
    index = '0;
    any   = 1'b0;
    for (int k = 1; k <= PORT_NB; k++) begin
      logic [IDX_W-1:0] cand;
      cand = IDX_W'((int'(ptr) + k) % PORT_NB);
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        index       = cand;
      end
    end
  end

endmodule

// File: rtl/axis_wrr_arbiter.sv
// Packet-granular weighted round-robin arbiter: PORT_NB AXI-Stream slaves into
// one registered master, each grant serving up to cfg_weight packets.
module axis_wrr_arbiter
  import axis_pkg::*;
#(
  parameter int AXIS_DWIDTH = 8,
  parameter int PORT_NB     = 4,
  parameter int WEIGHT_W    = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [PORT_NB*WEIGHT_W-1:0]    cfg_weight,
  input  logic [PORT_NB*AXIS_DWIDTH-1:0] s_tdata,
  input  logic [PORT_NB-1:0]             s_tlast,
  input  logic [PORT_NB-1:0]             s_tvalid,
  output logic [PORT_NB-1:0]             s_tready,
  output logic [AXIS_DWIDTH-1:0]         m_tdata,
  output logic                           m_tlast,
  output logic                           m_tvalid,
  input  logic                           m_tready,
  output logic [$clog2(PORT_NB)-1:0]     m_tid,
  output logic                           busy
);

  localparam int IDX_W = idx_w(PORT_NB);

  wrr_state_t            state;
  logic [IDX_W-1:0]      grant;
  logic [PORT_NB-1:0]    grant_oh;
  logic [IDX_W-1:0]      ptr;
  logic [WEIGHT_W-1:0]   credit;

  logic [PORT_NB-1:0]    sel_oh;
  logic [IDX_W-1:0]      sel_idx;
  logic                  sel_any;
  logic [WEIGHT_W-1:0]   sel_w;

  logic [AXIS_DWIDTH-1:0] g_data;
  logic                   g_last;
  logic                   g_valid;
  logic                   m_active;
  logic                   accept;

  // A zero weight still earns one packet per turn.
  function automatic logic [WEIGHT_W-1:0] turn_credit(input logic [WEIGHT_W-1:0] w);
    return (w == '0) ? WEIGHT_W'(1) : w;
  endfunction

  rr_select #(
    .PORT_NB (PORT_NB),
    .IDX_W   (IDX_W)
  ) u_rr_select (
    .req   (s_tvalid),
    .ptr   (ptr),
    .grant (sel_oh),
    .index (sel_idx),
    .any   (sel_any)
  );

  always_comb begin
    sel_w   = '0;
    g_data  = '0;
    g_last  = 1'b0;
    g_valid = 1'b0;
    for (int i = 0; i < PORT_NB; i++) begin
      if (sel_idx == IDX_W'(i)) sel_w = cfg_weight[i*WEIGHT_W +: WEIGHT_W];
      if (grant == IDX_W'(i)) begin
        g_data  = s_tdata[i*AXIS_DWIDTH +: AXIS_DWIDTH];
        g_last  = s_tlast[i];
        g_valid = s_tvalid[i];
      end
    end
  end

  assign m_active = ~m_tvalid | m_tready;
  assign s_tready = (state == STREAM) ? (grant_oh & {PORT_NB{m_active}}) : '0;
  assign accept   = (state == STREAM) & g_valid & m_active;
  assign busy     = (state != IDLE);

  // Stage p0: grant / credit control. Grant only moves in IDLE, so a packet
  // in flight is never cut regardless of other requests or master stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      grant_oh <= '0;
      credit   <= '0;
      ptr      <= IDX_W'(PORT_NB - 1);
    end else begin
      case (state)
        IDLE: begin
          if (sel_any) begin
            grant    <= sel_idx;
            grant_oh <= sel_oh;
            ptr      <= sel_idx;
            credit   <= turn_credit(sel_w);
            state    <= STREAM;
          end
        end
        STREAM: begin
          if (accept && g_last) begin
            if (credit == WEIGHT_W'(1)) begin
              state <= IDLE;
            end else begin
              credit <= credit - WEIGHT_W'(1);
              state  <= HOLD;
            end
          end
        end
        HOLD:    state <= g_valid ? STREAM : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Stage p1: master output register; holds while the master stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
      m_tdata  <= '0;
      m_tid    <= '0;
    end else if (accept) begin
      m_tvalid <= 1'b1;
      m_tlast  <= g_last;
      m_tdata  <= g_data;
      m_tid    <= grant;
    end else if (m_tready) begin
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_wrr_arbiter.sv
// Bench for axis_wrr_arbiter: queue-fed sources, packet-level WRR reference
// model, directed scenarios followed by randomized phases.
module tb_axis_wrr_arbiter;

  localparam int PN = 4;
  localparam int DW = 8;
  localparam int WW = 4;

  typedef struct packed { logic [DW-1:0] data; logic last; } beat_t;
  typedef struct packed { logic [DW-1:0] data; logic last; logic [1:0] tid; } obeat_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [PN*WW-1:0] cfg_weight;
  logic [PN*DW-1:0] s_tdata;
  logic [PN-1:0]  s_tlast;
  logic [PN-1:0]  s_tvalid;
  logic [PN-1:0]  s_tready;
  logic [DW-1:0]  m_tdata;
  logic           m_tlast;
  logic           m_tvalid;
  logic           m_tready;
  logic [1:0]     m_tid;
  logic           busy;

  always #5 clk = ~clk;

  axis_wrr_arbiter #(
    .AXIS_DWIDTH (DW),
    .PORT_NB     (PN),
    .WEIGHT_W    (WW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_weight (cfg_weight),
    .s_tdata    (s_tdata),
    .s_tlast    (s_tlast),
    .s_tvalid   (s_tvalid),
    .s_tready   (s_tready),
    .m_tdata    (m_tdata),
    .m_tlast    (m_tlast),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tid      (m_tid),
    .busy       (busy)
  );

  beat_t  srcq [PN][$];
  obeat_t expq [$];
  int     tid_seq [$];
  int     passed = 0;
  int     total = 0;
  int     fails = 0;
  int     mptr = PN - 1;
  int     edges = 0;
  int     first_edge = -1;
  int     last_edge = -1;
  int     tready_pct = 100;
  int     stall_at = 0;
  int     stall_len = 0;
  logic   stalled = 1'b0;
  obeat_t snap;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_w(input int w0, input int w1, input int w2, input int w3);
    cfg_weight = {WW'(w3), WW'(w2), WW'(w1), WW'(w0)};
  endtask

  task automatic gen_packet(input int port, input int len);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.data = DW'($urandom);
      b.last = (k == len - 1);
      srcq[port].push_back(b);
    end
  endtask

  task automatic drive_sources();
    for (int i = 0; i < PN; i++) begin
      if (srcq[i].size() > 0) begin
        s_tvalid[i]         = 1'b1;
        s_tdata[i*DW +: DW] = srcq[i][0].data;
        s_tlast[i]          = srcq[i][0].last;
      end else begin
        s_tvalid[i]         = 1'b0;
        s_tdata[i*DW +: DW] = '0;
        s_tlast[i]          = 1'b0;
      end
    end
  endtask

  task automatic set_tready();
    if (stall_len > 0 && edges >= stall_at && edges < stall_at + stall_len)
      m_tready = 1'b0;
    else
      m_tready = ($urandom_range(99, 0) < tready_pct);
  endtask

  // Packet-level WRR: next non-empty port after the pointer gets up to
  // max(weight,1) whole packets, stopping early if it runs dry.
  task automatic build_expected();
    beat_t  q [PN][$];
    beat_t  b;
    obeat_t o;
    int     p, g, cr;
    bit     found;
    for (int i = 0; i < PN; i++) q[i] = srcq[i];
    p = mptr;
    forever begin
      found = 1'b0;
      g = 0;
      for (int k = 1; k <= PN; k++) begin
        if (!found && q[(p + k) % PN].size() > 0) begin
          found = 1'b1;
          g = (p + k) % PN;
        end
      end
      if (!found) break;
      cr = int'(cfg_weight[g*WW +: WW]);
      if (cr == 0) cr = 1;
      while (cr > 0 && q[g].size() > 0) begin
        do begin
          b = q[g].pop_front();
          o.data = b.data;
          o.last = b.last;
          o.tid  = 2'(g);
          expq.push_back(o);
        end while (!b.last && q[g].size() > 0);
        cr--;
      end
      p = g;
    end
    mptr = p;
  endtask

  task automatic cycle();
    logic [PN-1:0] acc;
    obeat_t e;
    @(negedge clk);
    acc = s_tvalid & s_tready;
    check("s_tready_onehot", 32'($countones(s_tready) <= 1), 1);
    if (stalled) begin
      check("hold_valid", 32'(m_tvalid), 1);
      check("hold_data", 32'(m_tdata), 32'(snap.data));
      check("hold_last", 32'(m_tlast), 32'(snap.last));
      check("hold_tid", 32'(m_tid), 32'(snap.tid));
    end
    if (m_tvalid && m_tready) begin
      check("beat_expected", 32'(expq.size() > 0), 1);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        check("beat_data", 32'(m_tdata), 32'(e.data));
        check("beat_last", 32'(m_tlast), 32'(e.last));
        check("beat_tid", 32'(m_tid), 32'(e.tid));
      end
      if (m_tlast) tid_seq.push_back(int'(m_tid));
      last_edge = edges;
    end
    if (m_tvalid && first_edge < 0) first_edge = edges;
    stalled   = m_tvalid && !m_tready;
    snap.data = m_tdata;
    snap.last = m_tlast;
    snap.tid  = m_tid;
    @(posedge clk);
    #1;
    edges++;
    for (int i = 0; i < PN; i++)
      if (acc[i]) void'(srcq[i].pop_front());
    drive_sources();
    set_tready();
  endtask

  function automatic bit phase_idle();
    bit empty;
    empty = (expq.size() == 0) && !m_tvalid;
    for (int i = 0; i < PN; i++) if (srcq[i].size() > 0) empty = 1'b0;
    return empty;
  endfunction

  task automatic run_phase(input string name);
    int n, budget;
    bit done;
    budget = 50;
    for (int i = 0; i < PN; i++) budget += 20 * srcq[i].size();
    build_expected();
    edges = 0;
    first_edge = -1;
    last_edge = -1;
    tid_seq.delete();
    drive_sources();
    set_tready();
    n = 0;
    done = phase_idle();
    while (!done && n < budget) begin
      cycle();
      n++;
      done = phase_idle();
    end
    check({name, "_done"}, 32'(done), 1);
    if (!done) begin
      for (int i = 0; i < PN; i++) srcq[i].delete();
      expq.delete();
      drive_sources();
    end
  endtask

  task automatic check_seq(input string name, input int exp[$]);
    check({name, "_npkts"}, 32'(tid_seq.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < tid_seq.size(); i++)
      check($sformatf("%s_tid%0d", name, i), 32'(tid_seq[i]), 32'(exp[i]));
  endtask

  initial begin
    int     e[$];
    int     np;
    beat_t  b;
    obeat_t o;

    rst = 1'b1;
    m_tready = 1'b1;
    s_tvalid = '1;
    s_tlast = '0;
    s_tdata = '0;
    set_w(1, 1, 1, 1);
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_tvalid", 32'(m_tvalid), 0);
    check("rst_m_tlast", 32'(m_tlast), 0);
    check("rst_m_tid", 32'(m_tid), 0);
    check("rst_m_tdata", 32'(m_tdata), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_s_tready", 32'(s_tready), 0);
    s_tvalid = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 3-beat packet on port 2: first beat 2 edges later, then back-to-back
    b.last = 1'b0; b.data = 8'hA1; srcq[2].push_back(b);
    b.data = 8'hB2; srcq[2].push_back(b);
    b.last = 1'b1; b.data = 8'hC3; srcq[2].push_back(b);
    run_phase("r031");
    check("r031_first_edge", 32'(first_edge), 2);
    check("r031_last_edge", 32'(last_edge), 4);
    e = '{2};
    check_seq("r031", e);

    // Lone requester: one bubble per packet boundary
    for (int k = 0; k < 3; k++) gen_packet(3, 2);
    run_phase("bubble");
    check("bubble_first_edge", 32'(first_edge), 2);
    check("bubble_last_edge", 32'(last_edge), 9);
    e = '{3, 3, 3};
    check_seq("bubble", e);

    // Port 0 weight 3 but only one packet: HOLD then IDLE, port 2 next
    set_w(3, 1, 1, 1);
    gen_packet(0, 2);
    gen_packet(2, 1);
    run_phase("r035");
    check("r035_last_edge", 32'(last_edge), 6);
    e = '{0, 2};
    check_seq("r035", e);

    set_w(1, 1, 1, 1);
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < PN; i++) gen_packet(i, 1);
    run_phase("r032");
    e = '{3, 0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2};
    check_seq("r032", e);

    set_w(1, 3, 1, 1);
    for (int k = 0; k < 2; k++) gen_packet(0, 2);
    for (int k = 0; k < 6; k++) gen_packet(1, 1 + (k % 2));
    run_phase("r033");
    e = '{0, 1, 1, 1, 0, 1, 1, 1};
    check_seq("r033", e);

    // Reset while the 2nd beat of a 4-beat packet is being accepted
    set_w(1, 1, 1, 1);
    b.last = 1'b0; b.data = 8'h11; srcq[1].push_back(b);
    b.data = 8'h22; srcq[1].push_back(b);
    b.data = 8'h33; srcq[1].push_back(b);
    b.last = 1'b1; b.data = 8'h44; srcq[1].push_back(b);
    o.data = 8'h11; o.last = 1'b0; o.tid = 2'd1;
    expq.push_back(o);
    edges = 0;
    drive_sources();
    m_tready = 1'b1;
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    check("r036_m_tvalid", 32'(m_tvalid), 0);
    check("r036_busy", 32'(busy), 0);
    check("r036_s_tready", 32'(s_tready), 0);
    check("r036_beat1_seen", 32'(expq.size()), 0);
    rst = 1'b0;
    for (int i = 0; i < PN; i++) srcq[i].delete();
    mptr = PN - 1;
    gen_packet(3, 2);
    gen_packet(0, 2);
    run_phase("r036");
    e = '{0, 3};
    check_seq("r036", e);

    // Five-cycle master stall inside port 1's packet while port 3 waits
    gen_packet(1, 4);
    gen_packet(3, 2);
    stall_at = 3;
    stall_len = 5;
    run_phase("r034");
    stall_len = 0;
    e = '{1, 3};
    check_seq("r034", e);

    for (int r = 0; r < 8; r++) begin
      set_w($urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(3, 0));
      tready_pct = $urandom_range(100, 40);
      for (int i = 0; i < PN; i++) begin
        np = $urandom_range(3, 0);
        for (int k = 0; k < np; k++) gen_packet(i, $urandom_range(4, 1));
      end
      run_phase($sformatf("rnd%0d", r));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
